// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared states, widths and defaults for the SPI bus arbiter.
package spi_arb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, DONE} state_t;
    localparam int BYTE_W = 8;
    localparam int DEFAULT_TIMEOUT = 1024;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr and wraps.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [ptr_w(N)-1:0] ptr,
    output logic [N-1:0]        gnt,
    output logic [ptr_w(N)-1:0] idx,
    output logic                valid
);
    localparam int PW = ptr_w(N);
    int k;
    always_comb begin
        gnt = '0;
        idx = '0;
        k = 0;
        // Walk the search order backwards so the nearest requester is written last.
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = PW'(k);
            end
        end
        valid = |req;
    end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sequencer sharing one SPI master among NUM_REQ requesters.
// Optional watchdog on the master handshake enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rw_i,
    input  logic [BYTE_W*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [BYTE_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      m_start_o,
    output logic                      m_rw_o,
    output logic [BYTE_W-1:0]         m_wdata_o,
    input  logic [BYTE_W-1:0]         m_rdata_i,
    input  logic                      m_ready_i,
    output logic [NUM_REQ-1:0]        ss_n_o
);
    localparam int PW = ptr_w(NUM_REQ);
    state_t state, state_nx;
    logic [PW-1:0] ptr, win_idx, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic arb_valid, timeout;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req(req_i), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx), .valid(arb_valid)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i || state == ISSUE) cnt <= '0;
        else if (state == ACK || state == WAIT) cnt <= cnt + 1'b1;
    end
    // Fires as the count steps to TIMEOUT_CYCLES-1, so DONE lands TIMEOUT_CYCLES after ISSUE.
    assign timeout = (state == ACK || state == WAIT) && cnt == CW'(TIMEOUT_CYCLES - 2);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = (arb_valid && m_ready_i) ? ISSUE : IDLE;
            ISSUE: state_nx = ACK;
            ACK:   state_nx = timeout ? DONE : (!m_ready_i ? WAIT : ACK);
            WAIT:  state_nx = (timeout || m_ready_i) ? DONE : WAIT;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr       <= '0;
            win_idx   <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= 1'b0;
            m_start_o <= 1'b0;
            m_rw_o    <= 1'b0;
            m_wdata_o <= '0;
            rdata_o   <= '0;
            ss_n_o    <= '1;
        end else begin
            m_start_o <= state == IDLE && state_nx == ISSUE;
            done_o    <= state_nx == DONE ? gnt_o : '0;
            err_o     <= state_nx == DONE && timeout;
            if (state == IDLE && state_nx == ISSUE) begin
                gnt_o     <= arb_gnt;
                ss_n_o    <= ~arb_gnt;
                win_idx   <= arb_idx;
                m_rw_o    <= rw_i[arb_idx];
                m_wdata_o <= wdata_i[BYTE_W*arb_idx +: BYTE_W];
            end
            if (state_nx == DONE) begin
                ss_n_o  <= '1;
                rdata_o <= (m_rw_o && !timeout) ? m_rdata_i : '0;
            end
            if (state == DONE) begin
                gnt_o <= '0;
                ptr   <= PW'((int'(win_idx) + 1) % NUM_REQ);
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenario tasks with hand-computed expectations.
// Timeout scenario is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  rw_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  gnt_o, done_o, ss_n_o;
    logic [7:0]  rdata_o, m_wdata_o;
    logic        err_o, m_start_o, m_rw_o;
    logic [7:0]  m_rdata_i = '0;
    logic        m_ready_i = 1'b1;
    int pass_cnt = 0;
    int total = 0;
    bit ok;

    spi_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rw_i(rw_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .m_start_o(m_start_o), .m_rw_o(m_rw_o), .m_wdata_o(m_wdata_o),
        .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i), .ss_n_o(ss_n_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = m_start_o;
        end
    endtask

    // Entered in ISSUE; leaves the DUT in DONE after a full ready handshake.
    task automatic master_cycle(input logic [7:0] rd);
        m_ready_i = 1'b0;
        tick();
        tick();
        tick();
        m_ready_i = 1'b1;
        m_rdata_i = rd;
        tick();
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick();
        tick();
        total++; if (gnt_o !== 4'b0000) $display("FAIL rst_gnt got=%b exp=0000", gnt_o); else pass_cnt++;
        total++; if (done_o !== 4'b0000) $display("FAIL rst_done got=%b exp=0000", done_o); else pass_cnt++;
        total++; if (ss_n_o !== 4'b1111) $display("FAIL rst_ss_n got=%b exp=1111", ss_n_o); else pass_cnt++;
        total++; if ({err_o, m_start_o, m_rw_o} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {err_o, m_start_o, m_rw_o}); else pass_cnt++;
        total++; if ({m_wdata_o, rdata_o} !== 16'h0000) $display("FAIL rst_bytes got=%h exp=0000", {m_wdata_o, rdata_o}); else pass_cnt++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        req_i = 4'b0001;
        rw_i = 4'b0000;
        wdata_i = 32'h000000A5;
        tick();
        total++; if (m_start_o !== 1'b1) $display("FAIL wr_start got=%b exp=1", m_start_o); else pass_cnt++;
        total++; if (gnt_o !== 4'b0001) $display("FAIL wr_gnt got=%b exp=0001", gnt_o); else pass_cnt++;
        total++; if (ss_n_o !== 4'b1110) $display("FAIL wr_ss_n got=%b exp=1110", ss_n_o); else pass_cnt++;
        total++; if (m_wdata_o !== 8'hA5 || m_rw_o !== 1'b0) $display("FAIL wr_data got=%h/%b exp=a5/0", m_wdata_o, m_rw_o); else pass_cnt++;
        master_cycle(8'h99);
        req_i = 4'b0000;
        total++; if (done_o !== 4'b0001) $display("FAIL wr_done got=%b exp=0001", done_o); else pass_cnt++;
        total++; if (err_o !== 1'b0) $display("FAIL wr_err got=%b exp=0", err_o); else pass_cnt++;
        total++; if (rdata_o !== 8'h00) $display("FAIL wr_rdata got=%h exp=00", rdata_o); else pass_cnt++;
        tick();
        total++; if (done_o !== 4'b0000 || gnt_o !== 4'b0000) $display("FAIL wr_idle got=%b/%b exp=0000/0000", done_o, gnt_o); else pass_cnt++;
    endtask

    task automatic test_single_read;
        req_i = 4'b0100;
        rw_i = 4'b0100;
        wait_start(ok);
        total++; if (!ok) $display("FAIL rd_start got=none exp=pulse"); else pass_cnt++;
        total++; if (gnt_o !== 4'b0100 || m_rw_o !== 1'b1) $display("FAIL rd_gnt got=%b/%b exp=0100/1", gnt_o, m_rw_o); else pass_cnt++;
        master_cycle(8'h3C);
        req_i = 4'b0000;
        total++; if (done_o !== 4'b0100) $display("FAIL rd_done got=%b exp=0100", done_o); else pass_cnt++;
        total++; if (rdata_o !== 8'h3C) $display("FAIL rd_rdata got=%h exp=3c", rdata_o); else pass_cnt++;
        total++; if (ss_n_o !== 4'b1111) $display("FAIL rd_ss_n got=%b exp=1111", ss_n_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_contention;
        logic [3:0] order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
        logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h44};
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        rw_i = 4'b0000;
        wdata_i = 32'h44332211;
        req_i = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            if (n == 4) req_i = 4'b1001;
            wait_start(ok);
            total++; if (!ok || gnt_o !== order[n]) $display("FAIL cont_gnt%0d got=%b exp=%b", n, gnt_o, order[n]); else pass_cnt++;
            total++; if (m_wdata_o !== bytes[n]) $display("FAIL cont_wdata%0d got=%h exp=%h", n, m_wdata_o, bytes[n]); else pass_cnt++;
            master_cycle(8'h00);
            total++; if (done_o !== order[n]) $display("FAIL cont_done%0d got=%b exp=%b", n, done_o, order[n]); else pass_cnt++;
            req_i = req_i & ~order[n];
        end
        req_i = 4'b0000;
        tick();
    endtask

    task automatic test_drop_after_grant;
        req_i = 4'b0010;
        rw_i = 4'b0000;
        wdata_i = 32'h00005A00;
        wait_start(ok);
        total++; if (!ok || gnt_o !== 4'b0010) $display("FAIL drop_gnt got=%b exp=0010", gnt_o); else pass_cnt++;
        req_i = 4'b0000;
        rw_i = 4'b1111;
        wdata_i = 32'hFFFFFFFF;
        master_cycle(8'h77);
        total++; if (done_o !== 4'b0010) $display("FAIL drop_done got=%b exp=0010", done_o); else pass_cnt++;
        total++; if (m_wdata_o !== 8'h5A || m_rw_o !== 1'b0) $display("FAIL drop_latch got=%h/%b exp=5a/0", m_wdata_o, m_rw_o); else pass_cnt++;
        total++; if (rdata_o !== 8'h00) $display("FAIL drop_rdata got=%h exp=00", rdata_o); else pass_cnt++;
        rw_i = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_wait;
        req_i = 4'b1000;
        wait_start(ok);
        total++; if (!ok || gnt_o !== 4'b1000) $display("FAIL rstw_gnt got=%b exp=1000", gnt_o); else pass_cnt++;
        req_i = 4'b0000;
        m_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++; if (ss_n_o !== 4'b1111 || gnt_o !== 4'b0000) $display("FAIL rstw_out got=%b/%b exp=1111/0000", ss_n_o, gnt_o); else pass_cnt++;
        total++; if (done_o !== 4'b0000) $display("FAIL rstw_done got=%b exp=0000", done_o); else pass_cnt++;
        m_ready_i = 1'b1;
        tick();
        total++; if (done_o !== 4'b0000) $display("FAIL rstw_late_done got=%b exp=0000", done_o); else pass_cnt++;
        req_i = 4'b0101;
        wait_start(ok);
        total++; if (!ok || gnt_o !== 4'b0001) $display("FAIL rstw_ptr got=%b exp=0001", gnt_o); else pass_cnt++;
        master_cycle(8'h00);
        req_i = 4'b0000;
        total++; if (done_o !== 4'b0001) $display("FAIL rstw_done2 got=%b exp=0001", done_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_ready_block;
        m_ready_i = 1'b0;
        req_i = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (m_start_o !== 1'b0 || gnt_o !== 4'b0000) $display("FAIL blk_hold got=%b/%b exp=0/0000", m_start_o, gnt_o); else pass_cnt++;
        m_ready_i = 1'b1;
        tick();
        total++; if (m_start_o !== 1'b1 || gnt_o !== 4'b0001) $display("FAIL blk_release got=%b/%b exp=1/0001", m_start_o, gnt_o); else pass_cnt++;
        master_cycle(8'h00);
        req_i = 4'b0000;
        total++; if (done_o !== 4'b0001) $display("FAIL blk_done got=%b exp=0001", done_o); else pass_cnt++;
        tick();
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cycles;
        req_i = 4'b0100;
        rw_i = 4'b0100;
        m_rdata_i = 8'hC3;
        wait_start(ok);
        total++; if (!ok) $display("FAIL to_start got=none exp=pulse"); else pass_cnt++;
        m_ready_i = 1'b0;
        req_i = 4'b0000;
        cycles = 0;
        for (int i = 0; i < 40 && done_o === 4'b0000; i++) begin
            tick();
            cycles++;
        end
        total++; if (cycles != 16) $display("FAIL to_latency got=%0d exp=16", cycles); else pass_cnt++;
        total++; if (err_o !== 1'b1 || done_o !== 4'b0100) $display("FAIL to_err got=%b/%b exp=1/0100", err_o, done_o); else pass_cnt++;
        total++; if (rdata_o !== 8'h00 || ss_n_o !== 4'b1111) $display("FAIL to_rdata got=%h/%b exp=00/1111", rdata_o, ss_n_o); else pass_cnt++;
        tick();
        total++; if (err_o !== 1'b0) $display("FAIL to_err_pulse got=%b exp=0", err_o); else pass_cnt++;
        m_ready_i = 1'b1;
        rw_i = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_drop_after_grant();
        test_reset_in_wait();
        test_ready_block();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
